// File: rtl/plic_core_ctrl_pkg.sv
// Shared constants and types for the platform-level interrupt controller core.
package plic_core_ctrl_pkg;

  localparam int PLIC_NUM_SOURCES = 32;
  localparam int PLIC_PRIO_WIDTH  = 3;
  localparam int PLIC_ADDR_WIDTH  = 12;
  // Interrupt IDs travel in 5 bits (claim value, complete wdata[4:0]).
  localparam int PLIC_ID_WIDTH    = 5;

  // Register byte offsets.
  localparam logic [11:0] PLIC_PRIO_OFFSET      = 12'h000;
  localparam logic [11:0] PLIC_PENDING_OFFSET   = 12'h080;
  localparam logic [11:0] PLIC_ENABLE_OFFSET    = 12'h100;
  localparam logic [11:0] PLIC_THRESHOLD_OFFSET = 12'h200;
  localparam logic [11:0] PLIC_CLAIM_OFFSET     = 12'h204;

  // Static line assignment; line 0 is reserved.
  localparam int PLIC_GPIO_INTERRUPT = 1;
  localparam int PLIC_TIM0_INTERRUPT = 2;
  localparam int PLIC_TIM1_INTERRUPT = 3;
  localparam int PLIC_UART_INTERRUPT = 4;

  // Per-source gateway state.
  typedef enum logic {
    GW_IDLE  = 1'b0,
    GW_ARMED = 1'b1
  } gw_state_e;

endpackage

// File: rtl/plic_core_ctrl_if.sv
// Register port between the AXI-Lite slave adapter and the PLIC core.
//
// Handshake: the master pulses reg_req_i for one cycle per access together
// with reg_we_i/reg_addr_i/reg_wdata_i. The slave never stalls: reg_ack_o is
// high exactly one cycle later, and reg_rdata_o carries the read data during
// that cycle only (0 otherwise). A new request may be issued in the same
// cycle as the previous ack, giving one access per cycle.
interface plic_core_ctrl_if #(
  parameter int ADDR_WIDTH = 12
) ();

  logic                  reg_req_i;
  logic                  reg_we_i;
  logic [ADDR_WIDTH-1:0] reg_addr_i;
  logic [31:0]           reg_wdata_i;
  logic                  reg_ack_o;
  logic [31:0]           reg_rdata_o;

  modport slave (
    input  reg_req_i,
    input  reg_we_i,
    input  reg_addr_i,
    input  reg_wdata_i,
    output reg_ack_o,
    output reg_rdata_o
  );

  modport master (
    output reg_req_i,
    output reg_we_i,
    output reg_addr_i,
    output reg_wdata_i,
    input  reg_ack_o,
    input  reg_rdata_o
  );

endinterface

// File: rtl/plic_core_ctrl_gateway.sv
// Per-source gateway: arms on a level assertion, holds pending until claimed,
// and only re-arms after the handler completes the ID.
module plic_gateway
  import plic_core_ctrl_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_src,
  input  logic      i_claim_hit,
  input  logic      i_complete_hit,
  output logic      o_pending,
  output gw_state_e o_state
);

  gw_state_e r_state;
  gw_state_e w_state_next;
  logic      r_pending;
  logic      w_pending_next;

  // State and pending registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= GW_IDLE;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
    end
  end

  // Next state: assertions are ignored while ARMED, and a complete arriving
  // with a new assertion returns to IDLE; the level is picked up next cycle.
  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    case (r_state)
      GW_IDLE: begin
        if (i_src) begin
          w_state_next   = GW_ARMED;
          w_pending_next = 1'b1;
        end
      end
      GW_ARMED: begin
        if (i_complete_hit) begin
          w_state_next = GW_IDLE;
        end
      end
      default: w_state_next = GW_IDLE;
    endcase
    if (i_claim_hit) begin
      w_pending_next = 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_state   = r_state;

endmodule

// File: rtl/plic_core_ctrl.sv
// Single-target PLIC core: gateways, priority arbiter, threshold compare and
// the word register port (priority, pending, enable, threshold, claim/complete).
module plic_core_ctrl
  import plic_core_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES = PLIC_NUM_SOURCES,
  parameter int PRIO_WIDTH  = PLIC_PRIO_WIDTH,
  parameter int ADDR_WIDTH  = PLIC_ADDR_WIDTH
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_SOURCES-1:0] irq_src_i,
  plic_core_ctrl_if.slave        reg_if,
  output logic                   irq_o,
  // Debug view of which gateways are ARMED (bit 0 always 0).
  output logic [NUM_SOURCES-1:0] o_dbg_armed
);

  // Register file.
  logic [PRIO_WIDTH-1:0]    r_prio [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]   r_enable;
  logic [PRIO_WIDTH-1:0]    r_threshold;

  // Arbiter result and outputs.
  logic [PLIC_ID_WIDTH-1:0] r_best_id;
  logic [PRIO_WIDTH-1:0]    r_best_prio;
  logic                     r_irq;
  logic                     r_ack;
  logic [31:0]              r_rdata;

  logic [NUM_SOURCES-1:0]   w_pending;
  logic [PLIC_ID_WIDTH-1:0] w_best_id;
  logic [PRIO_WIDTH-1:0]    w_best_prio;
  logic [PLIC_ID_WIDTH-1:0] w_claim_id;
  logic [ADDR_WIDTH-1:0]    w_word_addr;
  logic [4:0]               w_prio_idx;
  logic                     w_prio_sel;
  logic                     w_wr;
  logic                     w_rd;
  logic                     w_claim;
  logic                     w_complete;
  logic [31:0]              w_rdata;
  logic                     w_unused_bits;

  // Address decode; byte lanes within a word are ignored.
  assign w_word_addr = {reg_if.reg_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_prio_idx  = w_word_addr[6:2];
  assign w_prio_sel  = (w_word_addr < ADDR_WIDTH'(PLIC_PENDING_OFFSET));
  assign w_wr        = reg_if.reg_req_i &  reg_if.reg_we_i;
  assign w_rd        = reg_if.reg_req_i & ~reg_if.reg_we_i;
  assign w_claim     = w_rd & (w_word_addr == ADDR_WIDTH'(PLIC_CLAIM_OFFSET));
  assign w_complete  = w_wr & (w_word_addr == ADDR_WIDTH'(PLIC_CLAIM_OFFSET));

  // A zero-priority result means nothing claimable, so the claim returns 0.
  assign w_claim_id  = (r_best_prio != '0) ? r_best_id : '0;

  assign w_unused_bits = ^{reg_if.reg_addr_i[1:0], reg_if.reg_wdata_i, irq_src_i[0]};

  assign w_pending[0]   = 1'b0;
  assign o_dbg_armed[0] = 1'b0;

  for (genvar g = 1; g < NUM_SOURCES; g++) begin : g_gw
    gw_state_e w_state;

    plic_gateway u_gw (
      .i_clk          (clock_i),
      .i_rst          (reset_i),
      .i_src          (irq_src_i[g]),
      .i_claim_hit    (w_claim && (r_best_prio != '0) && (r_best_id == PLIC_ID_WIDTH'(g))),
      .i_complete_hit (w_complete && (reg_if.reg_wdata_i[4:0] == 5'(g))),
      .o_pending      (w_pending[g]),
      .o_state        (w_state)
    );

    assign o_dbg_armed[g] = (w_state == GW_ARMED);
  end

  // Register writes; priority[0] and enable[0] are hardwired to zero.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        r_prio[i] <= '0;
      end
      r_enable    <= '0;
      r_threshold <= '0;
    end else if (w_wr) begin
      if (w_prio_sel) begin
        for (int i = 1; i < NUM_SOURCES; i++) begin
          if (w_prio_idx == 5'(i)) begin
            r_prio[i] <= reg_if.reg_wdata_i[PRIO_WIDTH-1:0];
          end
        end
      end
      if (w_word_addr == ADDR_WIDTH'(PLIC_ENABLE_OFFSET)) begin
        r_enable <= {reg_if.reg_wdata_i[NUM_SOURCES-1:1], 1'b0};
      end
      if (w_word_addr == ADDR_WIDTH'(PLIC_THRESHOLD_OFFSET)) begin
        r_threshold <= reg_if.reg_wdata_i[PRIO_WIDTH-1:0];
      end
    end
  end

  // Arbiter: highest priority among pending & enabled lines; the strict
  // compare keeps the lowest ID on ties and drops priority-0 lines.
  always_comb begin
    w_best_id   = '0;
    w_best_prio = '0;
    for (int i = 1; i < NUM_SOURCES; i++) begin
      if (w_pending[i] && r_enable[i] && (r_prio[i] > w_best_prio)) begin
        w_best_id   = PLIC_ID_WIDTH'(i);
        w_best_prio = r_prio[i];
      end
    end
  end

  // Registered arbiter result; a claim blanks it for one cycle so the same
  // ID cannot be handed out twice before pending has cleared.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_best_id   <= '0;
      r_best_prio <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_claim) begin
        r_best_id   <= '0;
        r_best_prio <= '0;
      end else begin
        r_best_id   <= w_best_id;
        r_best_prio <= w_best_prio;
      end
      r_irq <= (r_best_prio > r_threshold);
    end
  end

  // Read mux; unmapped addresses and unimplemented bits read as zero.
  always_comb begin
    w_rdata = '0;
    if (w_prio_sel) begin
      for (int i = 1; i < NUM_SOURCES; i++) begin
        if (w_prio_idx == 5'(i)) begin
          w_rdata = 32'(r_prio[i]);
        end
      end
    end else if (w_word_addr == ADDR_WIDTH'(PLIC_PENDING_OFFSET)) begin
      w_rdata = 32'(w_pending);
    end else if (w_word_addr == ADDR_WIDTH'(PLIC_ENABLE_OFFSET)) begin
      w_rdata = 32'(r_enable);
    end else if (w_word_addr == ADDR_WIDTH'(PLIC_THRESHOLD_OFFSET)) begin
      w_rdata = 32'(r_threshold);
    end else if (w_word_addr == ADDR_WIDTH'(PLIC_CLAIM_OFFSET)) begin
      w_rdata = 32'(w_claim_id);
    end
  end

  // One-cycle response: ack follows every request, data only for reads.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= reg_if.reg_req_i;
      r_rdata <= w_rd ? w_rdata : '0;
    end
  end

  assign reg_if.reg_ack_o   = r_ack;
  assign reg_if.reg_rdata_o = r_rdata;
  assign irq_o              = r_irq;

endmodule
